// File: rtl/stochastic_tfhe_pkg.sv
// Shared constants and FSM state type for the stochastic TFHE slice.
package stochastic_tfhe_pkg;
  localparam int unsigned Q_BITS      = 10;
  localparam int unsigned P_BITS      = 8;
  localparam int unsigned DELTA_SHIFT = 2;
  localparam int unsigned STREAM_LEN  = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StEnc,
    StStream,
    StDec,
    StDone
  } state_e;
endpackage

// File: rtl/stochastic_mux_adder.sv
// One ciphertext lane: unary comparators, alternating MUX, deserialising counter, parity fix.
module stochastic_mux_adder
  import stochastic_tfhe_pkg::*;
(
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_en,
  input  logic [Q_BITS-1:0] i_cnt,
  input  logic [Q_BITS-1:0] i_x,
  input  logic [Q_BITS-1:0] i_y,
  output logic [Q_BITS-1:0] o_deser,
  output logic [Q_BITS-1:0] o_sum
);
  logic              w_x_bit;
  logic              w_y_bit;
  logic              w_mux;
  logic [Q_BITS-1:0] r_deser;

  assign w_x_bit = (i_cnt < i_x);
  assign w_y_bit = (i_cnt < i_y);
  // Even cycles sample x, odd cycles sample y: each stream contributes half its ones.
  assign w_mux   = i_cnt[0] ? w_y_bit : w_x_bit;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_deser <= '0;
    end else if (i_clear) begin
      r_deser <= '0;
    end else if (i_en) begin
      r_deser <= r_deser + {{(Q_BITS-1){1'b0}}, w_mux};
    end
  end

  // 2*(ceil(x/2)+floor(y/2)) - x[0] + y[0] == x + y.
  assign o_sum   = {r_deser[Q_BITS-2:0], 1'b0} - {{(Q_BITS-1){1'b0}}, i_x[0]}
                 + {{(Q_BITS-1){1'b0}}, i_y[0]};
  assign o_deser = r_deser;
endmodule

// File: rtl/stochastic_processor_slice.sv
// Encrypts two bytes as LWE ciphertexts, adds them with stochastic MUX lanes, decrypts the sum.
module stochastic_processor_slice
  import stochastic_tfhe_pkg::*;
#(
  parameter logic [Q_BITS-1:0] SECRET_KEY = 10'd739
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [P_BITS-1:0] byte1,
  input  logic [Q_BITS-1:0] public_key1,
  input  logic [P_BITS-1:0] byte2,
  input  logic [Q_BITS-1:0] public_key2,
  output logic [P_BITS-1:0] res,
  output logic              done
);
  localparam logic [Q_BITS-1:0] LAST_CNT = Q_BITS'(STREAM_LEN - 1);

  state_e              r_state, w_state_d;
  logic [P_BITS-1:0]   r_byte1, r_byte2, r_res;
  logic [Q_BITS-1:0]   r_pk1, r_pk2, r_cnt;
  logic                r_done;
  logic [2*Q_BITS-1:0] ct1, ct2, ct_sum;
  logic [Q_BITS-1:0]   deser_a, deser_b;
  logic [Q_BITS-1:0]   w_b1, w_b2, w_sum_a, w_sum_b, w_phase, w_round;
  logic                w_clear, w_en;

  assign w_b1    = r_pk1 * SECRET_KEY + {r_byte1, {DELTA_SHIFT{1'b0}}};
  assign w_b2    = r_pk2 * SECRET_KEY + {r_byte2, {DELTA_SHIFT{1'b0}}};
  assign w_phase = w_sum_b - w_sum_a * SECRET_KEY;
  assign w_round = w_phase + 10'd2;
  assign w_clear = (r_state == StIdle) && start;
  assign w_en    = (r_state == StStream);

  stochastic_mux_adder u_lane_a (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (w_clear),
    .i_en    (w_en),
    .i_cnt   (r_cnt),
    .i_x     (ct1[2*Q_BITS-1:Q_BITS]),
    .i_y     (ct2[2*Q_BITS-1:Q_BITS]),
    .o_deser (deser_a),
    .o_sum   (w_sum_a)
  );

  stochastic_mux_adder u_lane_b (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_clear (w_clear),
    .i_en    (w_en),
    .i_cnt   (r_cnt),
    .i_x     (ct1[Q_BITS-1:0]),
    .i_y     (ct2[Q_BITS-1:0]),
    .o_deser (deser_b),
    .o_sum   (w_sum_b)
  );

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (start) w_state_d = StEnc;
      StEnc:    w_state_d = StStream;
      StStream: if (r_cnt == LAST_CNT) w_state_d = StDec;
      StDec:    w_state_d = StDone;
      StDone:   w_state_d = StIdle;
      default:  w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_byte1 <= '0;
      r_byte2 <= '0;
      r_pk1   <= '0;
      r_pk2   <= '0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_done  <= 1'b0;
      ct1     <= '0;
      ct2     <= '0;
      ct_sum  <= '0;
    end else begin
      r_state <= w_state_d;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (start) begin
            r_byte1 <= byte1;
            r_byte2 <= byte2;
            r_pk1   <= public_key1;
            r_pk2   <= public_key2;
          end
        end
        StEnc: begin
          ct1   <= {r_pk1, w_b1};
          ct2   <= {r_pk2, w_b2};
          r_cnt <= '0;
        end
        StStream: r_cnt <= r_cnt + 10'd1;
        StDec: begin
          ct_sum <= {w_sum_a, w_sum_b};
          r_res  <= w_round[Q_BITS-1:DELTA_SHIFT];
        end
        StDone:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign res  = r_res;
  assign done = r_done;
endmodule

// File: tb/tb_stochastic_processor_slice.sv
// Directed bench for stochastic_processor_slice: encryption, stochastic add, decrypt, timing.
module tb_stochastic_processor_slice;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] byte1 = '0, byte2 = '0;
  logic [9:0] public_key1 = '0, public_key2 = '0;
  logic [7:0] res;
  logic       done;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  stochastic_processor_slice dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .byte1       (byte1),
    .public_key1 (public_key1),
    .byte2       (byte2),
    .public_key2 (public_key2),
    .res         (res),
    .done        (done)
  );

  // Launch one op and count edges from the start-sampling edge until done is seen (0 = timeout).
  task automatic run_op(input logic [7:0] b1, input logic [9:0] pk1, input logic [7:0] b2,
                        input logic [9:0] pk2, output int cycles);
    @(negedge clk);
    byte1 = b1; public_key1 = pk1; byte2 = b2; public_key2 = pk2;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        cycles = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if (res !== 8'd0) begin n_fail++; $display("FAIL reset_res got %0d want 0", res); end
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b want 0", done); end
    n_checks++;
    if (dut.ct_sum !== 20'd0) begin
      n_fail++; $display("FAIL reset_ct_sum got %0h want 0", dut.ct_sum);
    end
    @(negedge clk) rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (done !== 1'b0) begin n_fail++; $display("FAIL idle_done got %b want 0", done); end
    end
  endtask

  task automatic test_basic();
    int cyc;
    run_op(8'd5, 10'd234, 8'd3, 10'd567, cyc);
    n_checks++;
    if (cyc !== 1027) begin n_fail++; $display("FAIL basic_latency got %0d want 1027", cyc); end
    n_checks++;
    if (res !== 8'd8) begin n_fail++; $display("FAIL basic_res got %0d want 8", res); end
    n_checks++;
    if (dut.ct1[19:10] !== 10'd234) begin
      n_fail++; $display("FAIL ct1_a got %0d want 234", dut.ct1[19:10]);
    end
    n_checks++;
    if (dut.ct2[19:10] !== 10'd567) begin
      n_fail++; $display("FAIL ct2_a got %0d want 567", dut.ct2[19:10]);
    end
    // 234*739 mod 1024 = 894, plus 5*4
    n_checks++;
    if (dut.ct1[9:0] !== 10'd914) begin
      n_fail++; $display("FAIL ct1_b got %0d want 914", dut.ct1[9:0]);
    end
    n_checks++;
    if (dut.ct_sum[19:10] !== 10'd801) begin
      n_fail++; $display("FAIL ct_sum_a got %0d want 801", dut.ct_sum[19:10]);
    end
    @(posedge clk);
    #1;
    n_checks++;
    if (done !== 1'b0) begin n_fail++; $display("FAIL done_width got %b want 0", done); end
  endtask

  task automatic test_values();
    logic [7:0] b1s [8] = '{8'd255, 8'd255, 8'd200, 8'd111, 8'd0, 8'd0,   8'd99, 8'd64};
    logic [7:0] b2s [8] = '{8'd1,   8'd255, 8'd100, 8'd222, 8'd0, 8'd123, 8'd0,  8'd128};
    logic [7:0] exps[8] = '{8'd0,   8'd254, 8'd44,  8'd77,  8'd0, 8'd123, 8'd99, 8'd192};
    logic [9:0] pks [8] = '{10'd1023, 10'd0, 10'd512, 10'd999, 10'd1, 10'd77, 10'd300, 10'd641};
    int cyc;
    for (int k = 0; k < 8; k++) begin
      run_op(b1s[k], pks[k], b2s[k], pks[7-k], cyc);
      n_checks++;
      if (cyc !== 1027) begin
        n_fail++; $display("FAIL values_latency[%0d] got %0d want 1027", k, cyc);
      end
      n_checks++;
      if (res !== exps[k]) begin
        n_fail++; $display("FAIL values_res[%0d] %0d+%0d got %0d want %0d",
                           k, b1s[k], b2s[k], res, exps[k]);
      end
    end
  endtask

  task automatic test_timing();
    int cyc;
    run_op(8'd17, 10'd100, 8'd25, 10'd900, cyc);
    n_checks++;
    if (cyc !== 1027) begin n_fail++; $display("FAIL timing_latency got %0d want 1027", cyc); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      n_checks++;
      if (res !== 8'd42) begin n_fail++; $display("FAIL timing_hold got %0d want 42", res); end
    end
  endtask

  task automatic test_start_ignored();
    int cyc;
    @(negedge clk);
    byte1 = 8'd10; public_key1 = 10'd11; byte2 = 8'd20; public_key2 = 10'd22;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    for (int i = 1; i <= 1200; i++) begin
      if (i == 500) begin
        byte1 = 8'd200; byte2 = 8'd1; start = 1'b1;
      end
      if (i == 502) start = 1'b0;
      @(posedge clk);
      #1;
      if (done) begin
        cyc = i;
        break;
      end
    end
    n_checks++;
    if (cyc !== 1027) begin n_fail++; $display("FAIL ignore_latency got %0d want 1027", cyc); end
    n_checks++;
    if (res !== 8'd30) begin n_fail++; $display("FAIL ignore_res got %0d want 30", res); end
  endtask

  task automatic test_reset_mid_stream();
    int cyc;
    bit seen;
    @(negedge clk);
    byte1 = 8'd50; public_key1 = 10'd5; byte2 = 8'd60; public_key2 = 10'd6;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (300) @(posedge clk);
    @(negedge clk) rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_checks++;
    if (res !== 8'd0) begin n_fail++; $display("FAIL midrst_res got %0d want 0", res); end
    @(negedge clk) rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (done) seen = 1'b1;
    end
    n_checks++;
    if (seen !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", seen); end
    run_op(8'd37, 10'd444, 8'd89, 10'd888, cyc);
    n_checks++;
    if (res !== 8'd126) begin n_fail++; $display("FAIL midrst_next got %0d want 126", res); end
  endtask

  task automatic test_back_to_back();
    int gap;
    @(negedge clk);
    byte1 = 8'd10; public_key1 = 10'd3; byte2 = 8'd20; public_key2 = 10'd4;
    start = 1'b1;
    @(posedge clk);
    #1;
    byte1 = 8'd1; byte2 = 8'd2;
    gap = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        gap = i;
        break;
      end
    end
    n_checks++;
    if (res !== 8'd30) begin n_fail++; $display("FAIL b2b_first got %0d want 30", res); end
    gap = 0;
    for (int i = 1; i <= 1200; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        gap = i;
        break;
      end
    end
    start = 1'b0;
    n_checks++;
    if (gap !== 1028) begin n_fail++; $display("FAIL b2b_gap got %0d want 1028", gap); end
    n_checks++;
    if (res !== 8'd3) begin n_fail++; $display("FAIL b2b_second got %0d want 3", res); end
    for (int i = 0; i < 1100; i++) begin
      @(posedge clk);
      #1;
      if (done) begin
        n_checks++; n_fail++;
        $display("FAIL b2b_extra got done=1 want 0");
        break;
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_values();
    test_timing();
    test_start_ignored();
    test_reset_mid_stream();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
